operand_fetch_sequencer: RTL and testbench
==========================================

Name: operand_fetch_sequencer

Overview:
- FSM that drives the control inputs of the CPU operand-fetch datapath (srcM/srcL, dstM/dstL, AddrM/AddrL, IdxM) for one decoded MSP430 instruction.
- Sequences extension-word reads, effective-address computation and operand reads, then signals done to the execute stage.
- Sits between the instruction decoder and the operand-fetch register/adder block; handshakes with the memory bus through mem_rd/mem_rdy.

Parameters:
- TIMEOUT, 15, max cycles a read state waits for mem_rdy before error (only with OF_TIMEOUT_EN)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- start  input  1  decoded instruction valid; sampled only in IDLE
- fmt  input  2  0 = double-operand, 1 = single-operand, 2 = jump, 3 = reserved (treated as jump)
- As  input  2  source/single-op addressing mode
- Ad  input  1  destination addressing mode (double-op only)
- bw  input  1  byte op; selects autoincrement step
- cg_hit  input  1  source is a constant-generator encoding; no memory access
- mem_rdy  input  1  MDB valid this cycle; MDB holds until the next read
- srcM, srcL, dstM, dstL  output  1 each  datapath controls
- AddrM  output  2  MAB/address mux select
- AddrL, IdxM  output  1 each  address latch, index-adder select
- rs_pc  output  1  force source register read port to PC
- mem_rd  output  1  memory read request
- pc_inc  output  1  one-cycle pulse: PC += 2
- rinc  output  1  one-cycle pulse: autoincrement operand register
- rinc_step  output  2  1 if bw else 2
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse: operands valid
- err  output  1  timeout flag (tied 0 without option)

Behaviour:
- Reset (rst = 0, any time, including mid-sequence): state = IDLE and every output = 0, including srcM/dstM and AddrM = 0. Outputs take these values immediately, not at the next clock edge.
- Registered outputs: srcM and dstM. Once set, they are held until the next accepted start, which clears both.
- All other outputs are decoded from the current state and are 0 unless listed below.

States:
- IDLE
  - start & fmt = 2/3 → DONE.
  - start & fmt = 0: As = 00 or cg_hit → DSTSEL; As = 01 → SX_RD; As = 10/11 → S_RD.
  - start & fmt = 1: As = 00 or cg_hit → DONE; As = 01 → DX_RD; As = 10/11 → D_IND.
- SX_RD: rs_pc = 1, AddrM = 2, mem_rd = 1. Hold until mem_rdy; on mem_rdy, pc_inc = 1 and go to SX_CALC.
- SX_CALC: AddrM = 0, IdxM = 0, AddrL = 1 (Addr = MDB + Rsrc), for one cycle → S_RD_A.
- S_RD: AddrM = 2, mem_rd = 1. On mem_rdy: srcL = 1, srcM ← 1, rinc = (As = 11), then go to DSTSEL.
- S_RD_A: AddrM = 0, mem_rd = 1. On mem_rdy: srcL = 1, srcM ← 1, then go to DSTSEL.
- DSTSEL (0 cycles, decoded in the same transition): Ad = 0 → DONE; Ad = 1 → DX_RD.
- DX_RD: same as SX_RD but goes to DX_CALC.
- DX_CALC: AddrM = 0, IdxM = 1, AddrL = 1 (Addr = MDB + Rdst) → D_RD.
- D_IND: AddrM = 3, AddrL = 1 (Addr = Rdst) → D_RD. rinc = (As = 11) in this cycle.
- D_RD: AddrM = 0, mem_rd = 1. On mem_rdy: dstL = 1, dstM ← 1 → DONE.
- DONE: done = 1 for one cycle → IDLE. Addr stays latched for writeback.

Boundary conditions:
- start while busy: ignored.
- start in the DONE cycle: ignored.
- start held high: re-accepted in the next IDLE cycle.
- mem_rdy outside a read state: ignored.
- mem_rdy already high on entry to a read state: completes in 1 cycle.
- Latency with zero-wait memory:
  - register/register: 2 cycles (start → DONE).
  - X(Rs), Y(Rd): 8 cycles.
  - @Rs+, Rd: 3 cycles.

Optional Feature:
- Macro: OF_TIMEOUT_EN.
- Enabled:
  - A 4-bit wait counter clears on entry to each read state and increments each cycle without mem_rdy.
  - Reaching TIMEOUT sets err (sticky until reset or the next accepted start), drops mem_rd, and forces DONE with done = 1.
  - srcL/dstL are not asserted on timeout.
- Disabled: no counter; err tied 0; read states wait indefinitely.

Test Plan:
- Reset: assert rst = 0 in SX_CALC → outputs 0 immediately, state IDLE; release, start fmt = 0 As = 00 Ad = 0 → done 2 cycles after start, srcM = dstM = 0.
- Indexed/indexed: fmt = 0 As = 01 Ad = 1, mem_rdy always 1 → pc_inc twice; AddrL with IdxM = 0 then IdxM = 1; srcL and dstL once each; done at cycle 8; srcM = dstM = 1.
- Autoincrement: fmt = 0 As = 11 bw = 1 → rinc single pulse with rinc_step = 1; bw = 0 → rinc_step = 2.
- Single-op indirect: fmt = 1 As = 10 → AddrM = 3 with AddrL = 1, then D_RD AddrM = 0 mem_rd, dstL on mem_rdy; cg_hit = 1 → no mem_rd, done in 2 cycles.
- Wait states: S_RD with mem_rdy low 3 cycles → mem_rd held 4 cycles, srcL only in the mem_rdy cycle; start pulses during busy have no effect.
- OF_TIMEOUT_EN, TIMEOUT = 15: mem_rdy stuck low → err = 1 and done after 15 wait cycles; next start clears err.

Source files
------------

// File: rtl/operand_fetch_sequencer.sv
// operand_fetch_sequencer: sequences extension-word reads, effective-address
// computation and operand reads for one decoded MSP430 instruction, then
// pulses done to the execute stage.
// Optional build macro: OF_TIMEOUT_EN adds a read-wait timeout (err flag).
module operand_fetch_sequencer
`ifdef OF_TIMEOUT_EN
  #(
    parameter int unsigned TIMEOUT = 15
  )
`endif
  (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] fmt,
  input  logic [1:0] As,
  input  logic       Ad,
  input  logic       bw,
  input  logic       cg_hit,
  input  logic       mem_rdy,
  output logic       srcM,
  output logic       srcL,
  output logic       dstM,
  output logic       dstL,
  output logic [1:0] AddrM,
  output logic       AddrL,
  output logic       IdxM,
  output logic       rs_pc,
  output logic       mem_rd,
  output logic       pc_inc,
  output logic       rinc,
  output logic [1:0] rinc_step,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SX_RD   = 4'd1,
    ST_SX_CALC = 4'd2,
    ST_S_RD    = 4'd3,
    ST_S_RD_A  = 4'd4,
    ST_DX_RD   = 4'd5,
    ST_DX_CALC = 4'd6,
    ST_D_IND   = 4'd7,
    ST_D_RD    = 4'd8,
    ST_DONE    = 4'd9
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [1:0] r_as;
  logic       r_ad;
  logic       r_bw;
  logic       r_src_m;
  logic       r_dst_m;

  logic       w_accept;
  logic       w_read;
  logic       w_tmo;
  logic       w_rd_ok;

  logic       w_src_l;
  logic       w_dst_l;
  logic [1:0] w_addr_m;
  logic       w_addr_l;
  logic       w_idx_m;
  logic       w_rs_pc;
  logic       w_mem_rd;
  logic       w_pc_inc;
  logic       w_rinc;
  logic [1:0] w_rinc_step;
  logic       w_busy;
  logic       w_done;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_read   = (r_state == ST_SX_RD) || (r_state == ST_DX_RD) ||
                    (r_state == ST_S_RD)  || (r_state == ST_S_RD_A) ||
                    (r_state == ST_D_RD);
  // A read completes only if it has not timed out in the same cycle
  assign w_rd_ok  = mem_rdy && !w_tmo;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; DSTSEL is folded into the transitions that reach it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (fmt[1]) begin
            w_state_nxt = ST_DONE;
          end else if (!fmt[0]) begin
            if ((As == 2'b00) || cg_hit) begin
              w_state_nxt = Ad ? ST_DX_RD : ST_DONE;
            end else if (As == 2'b01) begin
              w_state_nxt = ST_SX_RD;
            end else begin
              w_state_nxt = ST_S_RD;
            end
          end else begin
            if ((As == 2'b00) || cg_hit) begin
              w_state_nxt = ST_DONE;
            end else if (As == 2'b01) begin
              w_state_nxt = ST_DX_RD;
            end else begin
              w_state_nxt = ST_D_IND;
            end
          end
        end
      end
      ST_SX_RD: begin
        if (w_tmo) begin
          w_state_nxt = ST_DONE;
        end else if (mem_rdy) begin
          w_state_nxt = ST_SX_CALC;
        end
      end
      ST_SX_CALC: w_state_nxt = ST_S_RD_A;
      ST_S_RD, ST_S_RD_A: begin
        if (w_tmo) begin
          w_state_nxt = ST_DONE;
        end else if (mem_rdy) begin
          w_state_nxt = r_ad ? ST_DX_RD : ST_DONE;
        end
      end
      ST_DX_RD: begin
        if (w_tmo) begin
          w_state_nxt = ST_DONE;
        end else if (mem_rdy) begin
          w_state_nxt = ST_DX_CALC;
        end
      end
      ST_DX_CALC: w_state_nxt = ST_D_RD;
      ST_D_IND:   w_state_nxt = ST_D_RD;
      ST_D_RD: begin
        if (w_tmo || mem_rdy) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath control decode from the current state
  always_comb begin
    w_src_l     = 1'b0;
    w_dst_l     = 1'b0;
    w_addr_m    = 2'd0;
    w_addr_l    = 1'b0;
    w_idx_m     = 1'b0;
    w_rs_pc     = 1'b0;
    w_mem_rd    = 1'b0;
    w_pc_inc    = 1'b0;
    w_rinc      = 1'b0;
    w_rinc_step = 2'd0;
    w_busy      = (r_state != ST_IDLE);
    w_done      = 1'b0;
    case (r_state)
      ST_SX_RD, ST_DX_RD: begin
        w_rs_pc  = 1'b1;
        w_addr_m = 2'd2;
        w_mem_rd = !w_tmo;
        w_pc_inc = w_rd_ok;
      end
      ST_SX_CALC: begin
        w_addr_l = 1'b1;
      end
      ST_S_RD: begin
        w_addr_m = 2'd2;
        w_mem_rd = !w_tmo;
        w_src_l  = w_rd_ok;
        w_rinc   = w_rd_ok && (r_as == 2'b11);
      end
      ST_S_RD_A: begin
        w_mem_rd = !w_tmo;
        w_src_l  = w_rd_ok;
      end
      ST_DX_CALC: begin
        w_idx_m  = 1'b1;
        w_addr_l = 1'b1;
      end
      ST_D_IND: begin
        w_addr_m = 2'd3;
        w_addr_l = 1'b1;
        w_rinc   = (r_as == 2'b11);
      end
      ST_D_RD: begin
        w_mem_rd = !w_tmo;
        w_dst_l  = w_rd_ok;
      end
      ST_DONE: begin
        w_done = 1'b1;
      end
      default: ;
    endcase
    if (w_rinc) begin
      w_rinc_step = r_bw ? 2'd1 : 2'd2;
    end
  end

  // Instruction fields latched at accept; operand-valid flags held until next accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_as    <= 2'd0;
      r_ad    <= 1'b0;
      r_bw    <= 1'b0;
      r_src_m <= 1'b0;
      r_dst_m <= 1'b0;
    end else if (w_accept) begin
      r_as    <= As;
      r_ad    <= Ad;
      r_bw    <= bw;
      r_src_m <= 1'b0;
      r_dst_m <= 1'b0;
    end else begin
      if (w_src_l) begin
        r_src_m <= 1'b1;
      end
      if (w_dst_l) begin
        r_dst_m <= 1'b1;
      end
    end
  end

`ifdef OF_TIMEOUT_EN
  localparam int unsigned WAIT_W = 4;

  logic [WAIT_W-1:0] r_wait;
  logic              r_err;

  // Wait counter restarts on every state change; err is sticky until next accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_state_nxt != r_state) begin
        r_wait <= '0;
      end else if (w_read && !mem_rdy) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_tmo) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_tmo = w_read && (r_wait == WAIT_W'(TIMEOUT));
  assign err   = r_err;
`else
  assign w_tmo = 1'b0;
  assign err   = 1'b0;
`endif

  assign srcM      = r_src_m;
  assign dstM      = r_dst_m;
  assign srcL      = w_src_l;
  assign dstL      = w_dst_l;
  assign AddrM     = w_addr_m;
  assign AddrL     = w_addr_l;
  assign IdxM      = w_idx_m;
  assign rs_pc     = w_rs_pc;
  assign mem_rd    = w_mem_rd;
  assign pc_inc    = w_pc_inc;
  assign rinc      = w_rinc;
  assign rinc_step = w_rinc_step;
  assign busy      = w_busy;
  assign done      = w_done;

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Directed bench for operand_fetch_sequencer: each cycle compares the full
// packed control vector against a hand-computed expectation.
module tb_operand_fetch_sequencer;

  localparam logic [16:0] O_STEP1 = 17'h00001;
  localparam logic [16:0] O_STEP2 = 17'h00002;
  localparam logic [16:0] O_RINC  = 17'h00004;
  localparam logic [16:0] O_PCINC = 17'h00008;
  localparam logic [16:0] O_MEMRD = 17'h00010;
  localparam logic [16:0] O_RSPC  = 17'h00020;
  localparam logic [16:0] O_IDXM  = 17'h00040;
  localparam logic [16:0] O_ADDRL = 17'h00080;
  localparam logic [16:0] O_A2    = 17'h00200;
  localparam logic [16:0] O_A3    = 17'h00300;
  localparam logic [16:0] O_DSTL  = 17'h00400;
  localparam logic [16:0] O_DSTM  = 17'h00800;
  localparam logic [16:0] O_SRCL  = 17'h01000;
  localparam logic [16:0] O_SRCM  = 17'h02000;
  localparam logic [16:0] O_ERR   = 17'h04000;
  localparam logic [16:0] O_DONE  = 17'h08000;
  localparam logic [16:0] O_BUSY  = 17'h10000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] fmt;
  logic [1:0] As;
  logic       Ad;
  logic       bw;
  logic       cg_hit;
  logic       mem_rdy;
  logic       srcM, srcL, dstM, dstL;
  logic [1:0] AddrM;
  logic       AddrL, IdxM, rs_pc, mem_rd, pc_inc, rinc;
  logic [1:0] rinc_step;
  logic       busy, done, err;
  logic [16:0] w_outs;

  int n_cmp = 0;
  int n_err = 0;

  operand_fetch_sequencer u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .fmt       (fmt),
    .As        (As),
    .Ad        (Ad),
    .bw        (bw),
    .cg_hit    (cg_hit),
    .mem_rdy   (mem_rdy),
    .srcM      (srcM),
    .srcL      (srcL),
    .dstM      (dstM),
    .dstL      (dstL),
    .AddrM     (AddrM),
    .AddrL     (AddrL),
    .IdxM      (IdxM),
    .rs_pc     (rs_pc),
    .mem_rd    (mem_rd),
    .pc_inc    (pc_inc),
    .rinc      (rinc),
    .rinc_step (rinc_step),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  assign w_outs = {busy, done, err, srcM, srcL, dstM, dstL, AddrM, AddrL,
                   IdxM, rs_pc, mem_rd, pc_inc, rinc, rinc_step};

  task automatic check_eq(input string tag, input logic [16:0] got,
                          input logic [16:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  task automatic set_ins(input logic [1:0] f, input logic [1:0] a,
                         input logic d, input logic b, input logic cg);
    fmt = f; As = a; Ad = d; bw = b; cg_hit = cg;
  endtask

  // One cycle: drive start/mem_rdy after the falling edge, then compare
  task automatic cyc(input string tag, input logic st, input logic rdy,
                     input logic [16:0] exp);
    @(negedge clk);
    start   = st;
    mem_rdy = rdy;
    #1;
    check_eq(tag, w_outs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; mem_rdy = 1'b0;
    set_ins(2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("reset_idle", w_outs, 17'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // X(Rs), Y(Rd) with zero-wait memory: done on cycle 8
    set_ins(2'd0, 2'b01, 1'b1, 1'b0, 1'b0);
    cyc("ix_idle",   1'b1, 1'b1, 17'h0);
    cyc("ix_sx_rd",  1'b0, 1'b1, O_BUSY | O_RSPC | O_A2 | O_MEMRD | O_PCINC);
    cyc("ix_sx_calc",1'b0, 1'b1, O_BUSY | O_ADDRL);
    cyc("ix_s_rd_a", 1'b0, 1'b1, O_BUSY | O_MEMRD | O_SRCL);
    cyc("ix_dx_rd",  1'b0, 1'b1, O_BUSY | O_SRCM | O_RSPC | O_A2 | O_MEMRD | O_PCINC);
    cyc("ix_dx_calc",1'b0, 1'b1, O_BUSY | O_SRCM | O_ADDRL | O_IDXM);
    cyc("ix_d_rd",   1'b0, 1'b1, O_BUSY | O_SRCM | O_MEMRD | O_DSTL);
    cyc("ix_done",   1'b0, 1'b1, O_BUSY | O_SRCM | O_DSTM | O_DONE);
    cyc("ix_after",  1'b0, 1'b1, O_SRCM | O_DSTM);

    // @Rs+ byte: rinc step 1
    set_ins(2'd0, 2'b11, 1'b0, 1'b1, 1'b0);
    cyc("ai_b_idle", 1'b1, 1'b1, O_SRCM | O_DSTM);
    cyc("ai_b_s_rd", 1'b0, 1'b1, O_BUSY | O_A2 | O_MEMRD | O_SRCL | O_RINC | O_STEP1);
    cyc("ai_b_done", 1'b0, 1'b1, O_BUSY | O_DONE | O_SRCM);

    // @Rs+ word: rinc step 2
    set_ins(2'd0, 2'b11, 1'b0, 1'b0, 1'b0);
    cyc("ai_w_idle", 1'b1, 1'b1, O_SRCM);
    cyc("ai_w_s_rd", 1'b0, 1'b1, O_BUSY | O_A2 | O_MEMRD | O_SRCL | O_RINC | O_STEP2);
    cyc("ai_w_done", 1'b0, 1'b1, O_BUSY | O_DONE | O_SRCM);

    // Single-op @Rd: mem_rdy already high, ignored in D_IND
    set_ins(2'd1, 2'b10, 1'b0, 1'b0, 1'b0);
    cyc("ind_idle",  1'b1, 1'b1, O_SRCM);
    cyc("ind_d_ind", 1'b0, 1'b1, O_BUSY | O_A3 | O_ADDRL);
    cyc("ind_d_rd",  1'b0, 1'b1, O_BUSY | O_MEMRD | O_DSTL);
    cyc("ind_done",  1'b0, 1'b1, O_BUSY | O_DONE | O_DSTM);

    // Constant generator: no memory access
    set_ins(2'd1, 2'b10, 1'b0, 1'b0, 1'b1);
    cyc("cg_idle",   1'b1, 1'b0, O_DSTM);
    cyc("cg_done",   1'b0, 1'b0, O_BUSY | O_DONE);
    cyc("cg_after",  1'b0, 1'b0, 17'h0);

    // @Rs with three wait states; start pulses while busy and in DONE
    set_ins(2'd0, 2'b10, 1'b0, 1'b0, 1'b0);
    cyc("ws_idle",   1'b1, 1'b0, 17'h0);
    cyc("ws_wait0",  1'b1, 1'b0, O_BUSY | O_A2 | O_MEMRD);
    cyc("ws_wait1",  1'b0, 1'b0, O_BUSY | O_A2 | O_MEMRD);
    cyc("ws_wait2",  1'b1, 1'b0, O_BUSY | O_A2 | O_MEMRD);
    cyc("ws_rdy",    1'b0, 1'b1, O_BUSY | O_A2 | O_MEMRD | O_SRCL);
    cyc("ws_done",   1'b1, 1'b0, O_BUSY | O_DONE | O_SRCM);
    cyc("ws_idle1",  1'b0, 1'b1, O_SRCM);
    cyc("ws_idle2",  1'b0, 1'b0, O_SRCM);

    // Jump with start held high: re-accepted in the next IDLE cycle
    set_ins(2'd2, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc("jh_idle",   1'b1, 1'b0, O_SRCM);
    cyc("jh_done",   1'b1, 1'b0, O_BUSY | O_DONE);
    set_ins(2'd3, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc("jh_idle2",  1'b1, 1'b0, 17'h0);
    cyc("jh_done2",  1'b0, 1'b0, O_BUSY | O_DONE);
    cyc("jh_after",  1'b0, 1'b0, 17'h0);

    // Asynchronous reset in SX_CALC, then register/register
    set_ins(2'd0, 2'b01, 1'b1, 1'b0, 1'b0);
    cyc("rs_idle",   1'b1, 1'b1, 17'h0);
    cyc("rs_sx_rd",  1'b0, 1'b1, O_BUSY | O_RSPC | O_A2 | O_MEMRD | O_PCINC);
    cyc("rs_sx_calc",1'b0, 1'b1, O_BUSY | O_ADDRL);
    rst = 1'b0;
    #1;
    check_eq("rs_async", w_outs, 17'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_ins(2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc("rr_idle",   1'b1, 1'b0, 17'h0);
    cyc("rr_done",   1'b0, 1'b0, O_BUSY | O_DONE);
    cyc("rr_after",  1'b0, 1'b0, 17'h0);

`ifdef OF_TIMEOUT_EN
    // Stuck memory: 15 wait cycles, then timeout forces DONE with err
    set_ins(2'd0, 2'b10, 1'b0, 1'b0, 1'b0);
    cyc("to_idle",   1'b1, 1'b0, 17'h0);
    for (int i = 0; i < 15; i++) begin
      cyc("to_wait", 1'b0, 1'b0, O_BUSY | O_A2 | O_MEMRD);
    end
    cyc("to_expire", 1'b0, 1'b0, O_BUSY | O_A2);
    cyc("to_done",   1'b0, 1'b0, O_BUSY | O_DONE | O_ERR);
    cyc("to_sticky", 1'b0, 1'b0, O_ERR);
    set_ins(2'd2, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc("to_start",  1'b1, 1'b0, O_ERR);
    cyc("to_clear",  1'b0, 1'b0, O_BUSY | O_DONE);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
